// File: rtl/input_cond_pkg.sv
// rtl/input_cond_pkg.sv - shared constants, types and helpers for the input conditioner
package input_cond_pkg;

    localparam int N_IN_DEF         = 17;
    localparam int SYNC_STAGES_DEF  = 2;
    localparam int TICK_DIV_DEF     = 50000;
    localparam int STABLE_TICKS_DEF = 8;

    // Transition counter for the button bit, observable by software or an ILA
    typedef logic [15:0] chg_cnt_t;
    localparam chg_cnt_t CHG_CNT_MAX = 16'hFFFF;

    // Width of a debounce counter that must hold 0..stable_ticks
    function automatic int cnt_width(input int stable_ticks);
        return (stable_ticks < 1) ? 1 : $clog2(stable_ticks + 1);
    endfunction

endpackage

// File: rtl/input_cond_bit.sv
// rtl/input_cond_bit.sv - one synchroniser chain plus one tick-sampled debounce cell
module input_cond_bit
    import input_cond_pkg::*;
#(
    parameter int   SYNC_STAGES  = SYNC_STAGES_DEF,
    parameter int   STABLE_TICKS = STABLE_TICKS_DEF,
    parameter logic RST_VAL      = 1'b0
) (
    input  logic clk_i,
    input  logic arst_ni,
    input  logic tick,
    input  logic in,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int            CW   = cnt_width(STABLE_TICKS);
    localparam logic [CW-1:0] LAST = CW'(STABLE_TICKS - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt_q;
    logic                   s;

    assign s = sync_q[SYNC_STAGES-1];

    // Plain flop chain into clk_i; nothing may sit between the stages
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            sync_q <= {SYNC_STAGES{RST_VAL}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], in};
        end
    end

    // Accept a new level only after STABLE_TICKS consecutive differing samples
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            cnt_q <= '0;
            level <= RST_VAL;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            if (tick) begin
                if (s == level) begin
                    cnt_q <= '0;
                end else if (cnt_q == LAST) begin
                    cnt_q <= '0;
                    level <= s;
                    rise  <= s;
                    fall  <= ~s;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/input_cond.sv
// rtl/input_cond.sv - board input conditioner top; optional INPUT_COND_CHG_CNT_EN adds chg_cnt_o
module input_cond
    import input_cond_pkg::*;
#(
    parameter int              N_IN         = N_IN_DEF,
    parameter int              SYNC_STAGES  = SYNC_STAGES_DEF,
    parameter int              TICK_DIV     = TICK_DIV_DEF,
    parameter int              STABLE_TICKS = STABLE_TICKS_DEF,
    parameter logic [N_IN-1:0] RST_VAL      = '0
) (
    input  logic            clk_i,
    input  logic            arst_ni,
    input  logic [N_IN-1:0] in_i,
    output logic [N_IN-1:0] level_o,
    output logic [N_IN-1:0] rise_o,
    output logic [N_IN-1:0] fall_o,
    output logic            tick_o
`ifdef INPUT_COND_CHG_CNT_EN
    ,
    output chg_cnt_t        chg_cnt_o
`endif
);

    localparam int            PW       = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] pre_q;

    // Shared prescaler: tick_o is high for the cycle after the count hits its last value
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            pre_q  <= '0;
            tick_o <= 1'b0;
        end else begin
            tick_o <= (pre_q == PRE_LAST);
            pre_q  <= (pre_q == PRE_LAST) ? '0 : pre_q + 1'b1;
        end
    end

    for (genvar i = 0; i < N_IN; i++) begin : g_bit
        input_cond_bit #(
            .SYNC_STAGES  (SYNC_STAGES),
            .STABLE_TICKS (STABLE_TICKS),
            .RST_VAL      (RST_VAL[i])
        ) u_bit (
            .clk_i   (clk_i),
            .arst_ni (arst_ni),
            .tick    (tick_o),
            .in      (in_i[i]),
            .level   (level_o[i]),
            .rise    (rise_o[i]),
            .fall    (fall_o[i])
        );
    end

`ifdef INPUT_COND_CHG_CNT_EN
    chg_cnt_t chg_cnt_q;

    // Saturating count of accepted button transitions
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            chg_cnt_q <= '0;
        end else if ((rise_o[0] | fall_o[0]) && (chg_cnt_q != CHG_CNT_MAX)) begin
            chg_cnt_q <= chg_cnt_q + 1'b1;
        end
    end

    assign chg_cnt_o = chg_cnt_q;
`endif

endmodule

// File: tb/tb_input_cond.sv
// tb/tb_input_cond.sv - randomized self-checking bench for input_cond against a behavioural model
module tb_input_cond;
    import input_cond_pkg::*;

    localparam int N  = 17;
    localparam int TD = 4;
    localparam int ST = 3;
    localparam int SS = 2;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b1;
    logic [N-1:0] in_i  = '0;
    logic [N-1:0] level;
    logic [N-1:0] rise;
    logic [N-1:0] fall;
    logic         tick;
`ifdef INPUT_COND_CHG_CNT_EN
    chg_cnt_t     chg_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    input_cond #(
        .N_IN         (N),
        .SYNC_STAGES  (SS),
        .TICK_DIV     (TD),
        .STABLE_TICKS (ST),
        .RST_VAL      ('0)
    ) dut (
        .clk_i     (clk),
        .arst_ni   (rst_n),
        .in_i      (in_i),
        .level_o   (level),
        .rise_o    (rise),
        .fall_o    (fall),
        .tick_o    (tick)
`ifdef INPUT_COND_CHG_CNT_EN
        ,
        .chg_cnt_o (chg_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: input delay line, sample tick by cycle count, and
    // acceptance when the last ST tick samples all disagree with the level.
    logic [N-1:0] pipe [$];
    logic [N-1:0] hist [$];
    int           cyc;
    logic         m_tick;
    logic [N-1:0] m_level;
    logic [N-1:0] m_rise;
    logic [N-1:0] m_fall;
    int           m_chg;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        pipe = {};
        hist = {};
        for (int i = 0; i < SS; i++) pipe.push_back('0);
        for (int i = 0; i < ST; i++) hist.push_back('0);
        cyc     = 0;
        m_tick  = 1'b0;
        m_level = '0;
        m_rise  = '0;
        m_fall  = '0;
        m_chg   = 0;
    endtask

    task automatic model_step();
        logic [N-1:0] s;
        bit           all_diff;
        if (!rst_n) return;
        s = pipe.pop_front();
        pipe.push_back(in_i);
        m_rise = '0;
        m_fall = '0;
        if (m_tick) begin
            void'(hist.pop_front());
            hist.push_back(s);
            for (int b = 0; b < N; b++) begin
                all_diff = 1'b1;
                foreach (hist[j]) if (hist[j][b] == m_level[b]) all_diff = 1'b0;
                if (all_diff) begin
                    if (m_level[b]) m_fall[b] = 1'b1;
                    else            m_rise[b] = 1'b1;
                    m_level[b] = ~m_level[b];
                end
            end
        end
        if ((m_rise[0] || m_fall[0]) && m_chg < 65535) m_chg++;
        cyc++;
        m_tick = ((cyc % TD) == 0);
    endtask

    task automatic compare_all();
        check("tick", 32'(tick), 32'(m_tick));
        check("level", 32'(level), 32'(m_level));
        check("rise", 32'(rise), 32'(m_rise));
        check("fall", 32'(fall), 32'(m_fall));
`ifdef INPUT_COND_CHG_CNT_EN
        check("chg_cnt", 32'(chg_cnt), 32'(m_chg));
`endif
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic apply_reset(input int n);
        rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_level", 32'(level), 32'h0);
        check("rst_rise", 32'(rise), 32'h0);
        check("rst_fall", 32'(fall), 32'h0);
        check("rst_tick", 32'(tick), 32'h0);
`ifdef INPUT_COND_CHG_CNT_EN
        check("rst_chg", 32'(chg_cnt), 32'h0);
`endif
        repeat (n) cycle();
        rst_n = 1'b1;
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int first_tick, n_ticks, lat, n_pulse, n_other, rise_val, low_seen, hold;
        logic [N-1:0] mask;

        // Reset then idle
        apply_reset(3);
        first_tick = 0;
        n_ticks    = 0;
        for (int k = 1; k <= 12; k++) begin
            cycle();
            if (tick) begin
                n_ticks++;
                if (first_tick == 0) first_tick = k;
            end
        end
        check("first_tick", 32'(first_tick), 32'd4);
        check("tick_count", 32'(n_ticks), 32'd3);
        check("idle_level", 32'(level), 32'h0);

        // Clean rise on bit 0
        in_i[0] = 1'b1;
        lat     = 0;
        n_pulse = 0;
        for (int k = 1; k <= 24; k++) begin
            cycle();
            if (level[0] && lat == 0) lat = k;
            if (rise[0]) n_pulse++;
        end
        check("rise_latency_in_range", 32'(lat >= 11 && lat <= 14), 32'd1);
        check("rise_pulse_count", 32'(n_pulse), 32'd1);

        // Bounce on bit 16
        n_pulse = 0;
        for (int k = 0; k < 40; k++) begin
            in_i[16] = ((k / 3) % 2) == 0;
            cycle();
            if (rise[16] || fall[16]) n_pulse++;
        end
        check("bounce_no_pulse", 32'(n_pulse), 32'd0);
        in_i[16] = 1'b1;
        n_pulse  = 0;
        n_other  = 0;
        for (int k = 0; k < 24; k++) begin
            cycle();
            if (rise[16]) n_pulse++;
            if (fall[16]) n_other++;
        end
        check("settle_one_rise", 32'(n_pulse), 32'd1);
        check("settle_no_fall", 32'(n_other), 32'd0);

        // Short glitch on bit 5
        in_i[5] = 1'b1;
        repeat (24) cycle();
        check("glitch_pre_level", 32'(level[5]), 32'd1);
        in_i[5]  = 1'b0;
        n_pulse  = 0;
        low_seen = 0;
        for (int k = 0; k < 30; k++) begin
            if (k == 6) in_i[5] = 1'b1;
            cycle();
            if (fall[5]) n_pulse++;
            if (!level[5]) low_seen = 1;
        end
        check("glitch_no_fall", 32'(n_pulse), 32'd0);
        check("glitch_level_held", 32'(low_seen), 32'd0);

        // All bits together, then reset mid-count
        in_i = '0;
        apply_reset(2);
        repeat (4) cycle();
        in_i     = '1;
        n_pulse  = 0;
        rise_val = 0;
        for (int k = 0; k < 24; k++) begin
            cycle();
            if (rise != '0) begin
                n_pulse++;
                if (rise_val == 0) rise_val = int'(rise);
            end
        end
        check("all_rise_value", 32'(rise_val), 32'h1FFFF);
        check("all_rise_cycles", 32'(n_pulse), 32'd1);
        in_i = '0;
        repeat (6) cycle();
        apply_reset(2);
        check("mid_reset_no_fall", 32'(fall), 32'h0);

        // Randomized soak, with occasional asynchronous resets
        for (int it = 0; it < 500; it++) begin
            if ($urandom_range(0, 99) == 0) begin
                apply_reset($urandom_range(1, 3));
            end
            mask = N'($urandom & $urandom & $urandom);
            in_i = in_i ^ mask;
            hold = $urandom_range(1, 30);
            repeat (hold) cycle();
        end

`ifdef INPUT_COND_CHG_CNT_EN
        // Button transition counter and its saturation
        in_i = '0;
        apply_reset(2);
        for (int i = 0; i < 10; i++) begin
            in_i[0] = ~in_i[0];
            repeat (20) cycle();
        end
        check("chg_cnt_ten", 32'(chg_cnt), 32'd10);
        force dut.chg_cnt_q = 16'hFFFE;
        #1;
        release dut.chg_cnt_q;
        m_chg = 32'hFFFE;
        for (int i = 0; i < 3; i++) begin
            in_i[0] = ~in_i[0];
            repeat (20) cycle();
        end
        check("chg_cnt_sat", 32'(chg_cnt), 32'hFFFF);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/input_cond.md
Name: input_cond

Overview:
- Conditions raw board inputs (push buttons, slide switches) before they enter the sigma SoC's irq_btn_i and gpio_bi ports.
- Per input bit, in order:
  - multi-flop synchroniser into clk_i,
  - tick-sampled debounce filter,
  - one-cycle rise/fall pulses.
- Sits directly upstream of the SoC in each board top.
- Clocked by the PLL output clock.

Parameters:
- N_IN, 17, number of conditioned inputs (16 switches + 1 button).
- SYNC_STAGES, 2, synchroniser depth; legal range 2..4.
- TICK_DIV, 50000, clk_i cycles per sample tick; must be >= 2.
- STABLE_TICKS, 8, consecutive differing samples required to accept a new level; must be >= 1.
- RST_VAL, 0 (N_IN bits), reset value of the synchroniser flops and level_o.

Ports:
- clk_i  in  1  system clock.
- arst_ni  in  1  asynchronous active-low reset.
- in_i  in  N_IN  raw asynchronous inputs.
- level_o  out  N_IN  debounced level.
- rise_o  out  N_IN  one-cycle pulse on accepted 0->1.
- fall_o  out  N_IN  one-cycle pulse on accepted 1->0.
- tick_o  out  1  sample tick, one cycle wide.

Behaviour:
- Clocking and reset
  - One clock; reset is asynchronous and active-low (arst_ni); all flops clear on its assertion.
  - Release takes effect at the next clk_i edge.
- Reset values
  - Synchroniser flops = RST_VAL; level_o = RST_VAL.
  - rise_o = fall_o = 0; tick_o = 0.
  - Prescaler = 0; all stable counters = 0.
- Prescaler
  - Counts 0..TICK_DIV-1 and wraps to 0.
  - tick_o is registered and high for exactly the cycle after the counter equals TICK_DIV-1.
  - Period is exactly TICK_DIV cycles.
  - First tick_o after reset release is in cycle TICK_DIV.
- Synchroniser
  - Per bit, SYNC_STAGES flops in series; s = last stage.
  - No logic between the stages.
- Debounce cell (per bit): counter cnt, width clog2(STABLE_TICKS+1).
  - Counter and level update only in tick cycles; in non-tick cycles cnt and level hold.
  - In a tick cycle, s == level: cnt <= 0.
  - In a tick cycle, s != level and cnt+1 < STABLE_TICKS: cnt <= cnt+1.
  - In a tick cycle, s != level and cnt+1 == STABLE_TICKS: level <= s, cnt <= 0.
  - On the level update, rise_o or fall_o is asserted in the same cycle level_o changes, for one cycle only.
- Glitch rejection
  - A disturbance sampled on fewer than STABLE_TICKS consecutive ticks never changes level_o.
  - One matching sample restarts the count.
- Latency
  - A clean edge on in_i appears on level_o after SYNC_STAGES + (STABLE_TICKS-1)*TICK_DIV + 1 to SYNC_STAGES + STABLE_TICKS*TICK_DIV cycles.
- Boundary conditions
  - Bits are fully independent; any number may change on the same tick.
  - rise_o and fall_o are never both high for one bit.
  - STABLE_TICKS = 1: level follows s at each tick.
  - Reset mid-count discards partial counts and forces level_o back to RST_VAL, with no pulses.

Optional Feature:
- Macro: INPUT_COND_CHG_CNT_EN.
- With it:
  - Adds output chg_cnt_o, 16 bits.
  - Counts accepted transitions (rise or fall) on bit 0, i.e. the button.
  - Saturates at 16'hFFFF; reset value 0.
  - Lets software or ILA check bounce handling.
- Without it: the port and its counter are absent; all other behaviour is identical.

Decomposition:
- Package input_cond_pkg holds:
  - the default constants (TICK_DIV_DEF, STABLE_TICKS_DEF, SYNC_STAGES_DEF),
  - a cnt-width function,
  - typedef chg_cnt_t (16 bits).
- Sub-module input_cond_bit: one synchroniser chain plus one debounce cell.
  - Ports: clk_i, arst_ni, tick, in, level, rise, fall.
  - Parameters: SYNC_STAGES, STABLE_TICKS, RST_VAL bit.
- Top-level input_cond contains the shared prescaler and a generate loop of N_IN input_cond_bit instances.

Test Plan (all with TICK_DIV=4, STABLE_TICKS=3, SYNC_STAGES=2, N_IN=17, RST_VAL=0):
- Reset then idle:
  - Stimulus: hold arst_ni=0 for 3 cycles, release, keep in_i=0.
  - Required: level_o, rise_o and fall_o stay 0; tick_o first pulses at cycle 4 after release, then every 4 cycles.
- Clean rise:
  - Stimulus: in_i[0] 0->1 at cycle t and held.
  - Required: level_o[0]=1 within t+11..t+14; rise_o[0] high exactly one cycle, aligned with the level change.
- Bounce rejection:
  - Stimulus: in_i[16] toggles every 3 cycles for 40 cycles, then settles to 1.
  - Required: no rise_o or fall_o during the toggling; exactly one rise_o[16] after settling.
- Short glitch:
  - Stimulus: with level_o[5]=1, pulse in_i[5]=0 for 6 cycles.
  - Required: level_o[5] stays 1; fall_o[5] never asserts.
- Simultaneous bits and reset mid-count:
  - Stimulus 1: set in_i=17'h1FFFF.
  - Required: all rise_o bits pulse in the same cycle.
  - Stimulus 2: later drop in_i to 0 and assert arst_ni 6 cycles after the drop.
  - Required: level_o=0 immediately on reset assertion, with no fall_o pulse.
- INPUT_COND_CHG_CNT_EN defined:
  - Stimulus: 5 accepted rises and 5 accepted falls on bit 0.
  - Required: chg_cnt_o=10.
  - Stimulus: force the count to 16'hFFFE, then 3 more accepted transitions.
  - Required: chg_cnt_o=16'hFFFF.
